// File: rtl/rt_pkg.sv
`default_nettype none
// ============================================================================
//  Package  : rt_pkg
//  Purpose  : Shared types and constants for the triangle reader / result
//             writer SDRAM paths: 16.16 fixed-point type with its limits and
//             the Avalon-MM data-path constants both masters use.
//  Revision : 1.0  initial release
// ============================================================================
package rt_pkg;

  // 16.16 signed fixed point
  typedef logic signed [31:0] fip;

  localparam fip FIP_ONE = 32'sh0001_0000;
  localparam fip FIP_MIN = 32'sh8000_0000;
  localparam fip FIP_MAX = 32'sh7FFF_FFFF;

  // Avalon-MM halfword data path toward the SDRAM controller
  localparam int         AVMM_DW     = 16;
  localparam logic [1:0] AVMM_BE_ALL = 2'b11;

endpackage : rt_pkg
`default_nettype wire

// File: rtl/record_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module   : record_addr_gen
//  Purpose  : Byte address of a fixed-size record in a flat array:
//             rec = base + index * (NDWORDS*4), modulo 2^32.
//             Shared by the reader and the writer so both see one address map.
//  Ports    : i_base      [31:0] byte base address of the record array
//             i_index     [31:0] record index
//             o_rec_addr  [31:0] byte address of the record (wraps silently)
//  Revision : 1.0  initial release
// ============================================================================
module record_addr_gen #(
  parameter int NDWORDS = 3
) (
  input  logic [31:0] i_base,
  input  logic [31:0] i_index,
  output logic [31:0] o_rec_addr
);

  // Stride is a constant, so the multiply reduces to shifts and adds.
  localparam logic [31:0] c_STRIDE = 32'(NDWORDS * 4);

  logic [31:0] w_offset;

  // Product truncated to 32 bits: address wraps modulo 2^32 by design.
  assign w_offset   = i_index * c_STRIDE;
  assign o_rec_addr = i_base + w_offset;

endmodule : record_addr_gen
`default_nettype wire

// File: rtl/result_writer.sv
`default_nettype none
// ============================================================================
//  Module   : result_writer
//  Purpose  : Serialises one record of NDWORDS 32-bit words into 2*NDWORDS
//             16-bit Avalon-MM write beats at base + index*NDWORDS*4.
//             A one-deep pending buffer lets the producer queue the next
//             record while the current one is being written.
//  Ports    : i_clk, i_rstn            clock, synchronous active-low reset
//             i_baseaddr/i_index/i_data request fields, sampled on accept
//             i_write / o_ready         request handshake
//             o_busy                    record in flight or pending
//             o_done                    1-cycle pulse after last beat accepted
//             avm_m0_*                  Avalon-MM write master
//  Revision : 1.0  initial release
// ============================================================================
module result_writer
  import rt_pkg::*;
#(
  parameter int NDWORDS = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic [31:0]             i_baseaddr,
  input  logic [31:0]             i_index,
  input  logic [32*NDWORDS-1:0]   i_data,
  input  logic                    i_write,
  output logic                    o_ready,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    avm_m0_write,
  output logic [31:0]             avm_m0_address,
  output logic [AVMM_DW-1:0]      avm_m0_writedata,
  output logic [1:0]              avm_m0_byteenable,
  input  logic                    avm_m0_waitrequest
);

  localparam int              c_NBEATS = 2 * NDWORDS;
  localparam int              c_BW     = (c_NBEATS > 1) ? $clog2(c_NBEATS) : 1;
  localparam logic [c_BW-1:0] c_LAST   = c_BW'(c_NBEATS - 1);

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_WRITE = 1'b1;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [0:0]            r_state;
  logic [c_BW-1:0]       r_beat;
  logic [31:0]           r_act_addr;
  logic [32*NDWORDS-1:0] r_act_data;
  logic                  r_pend_valid;
  logic [31:0]           r_pend_addr;
  logic [32*NDWORDS-1:0] r_pend_data;
  logic                  r_done;

  logic [31:0]           w_req_addr;
  logic                  w_writing;
  logic                  w_accept;
  logic                  w_beat_acc;
  logic                  w_last_acc;
  logic [31:0]           w_beat_off;
  logic [AVMM_DW-1:0]    w_halves [c_NBEATS];

  // Record address is resolved at accept time so only addresses are stored.
  record_addr_gen #(
    .NDWORDS (NDWORDS)
  ) u_addr_gen (
    .i_base     (i_baseaddr),
    .i_index    (i_index),
    .o_rec_addr (w_req_addr)
  );

  // Halfword b is word b/2, low half for even b: that is exactly bits [16b+:16].
  for (genvar k = 0; k < c_NBEATS; k++) begin : g_half
    assign w_halves[k] = r_act_data[16*k +: 16];
  end

  assign w_writing  = (r_state == S_WRITE);
  assign w_accept   = i_write && !r_pend_valid;
  assign w_beat_acc = w_writing && !avm_m0_waitrequest;
  assign w_last_acc = w_beat_acc && (r_beat == c_LAST);
  assign w_beat_off = {{(31-c_BW){1'b0}}, r_beat, 1'b0};

  // Beat outputs are pure functions of held registers, so they stay stable
  // for as long as waitrequest stalls the current beat.
  assign avm_m0_write      = w_writing;
  assign avm_m0_address    = w_writing ? (r_act_addr + w_beat_off) : 32'd0;
  assign avm_m0_writedata  = w_writing ? w_halves[r_beat] : '0;
  assign avm_m0_byteenable = w_writing ? AVMM_BE_ALL : 2'b00;

  assign o_ready = !r_pend_valid;
  assign o_busy  = w_writing || r_pend_valid;
  assign o_done  = r_done;

  // --------------------------------------------------------------------------
  // FSM, beat counter, active/pending registers
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state      <= S_IDLE;
      r_beat       <= '0;
      r_act_addr   <= '0;
      r_act_data   <= '0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
      r_pend_data  <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_last_acc;

      case (r_state)
        S_IDLE: begin
          // Pending is always empty here, so a request goes straight to active.
          if (w_accept) begin
            r_act_addr <= w_req_addr;
            r_act_data <= i_data;
            r_beat     <= '0;
            r_state    <= S_WRITE;
          end
        end

        S_WRITE: begin
          if (w_beat_acc) begin
            if (r_beat == c_LAST) begin
              r_beat <= '0;
              if (r_pend_valid) begin
                r_act_addr   <= r_pend_addr;
                r_act_data   <= r_pend_data;
                r_pend_valid <= 1'b0;
              end else if (w_accept) begin
                // Request arriving on the final beat: skip the pending stage
                // so its beat 0 follows with no idle gap.
                r_act_addr <= w_req_addr;
                r_act_data <= i_data;
              end else begin
                r_state <= S_IDLE;
              end
            end else begin
              r_beat <= r_beat + 1'b1;
            end
          end

          // An accept implies pending was empty, so this never collides with
          // the pending->active transfer above.
          if (w_accept && !w_last_acc) begin
            r_pend_addr  <= w_req_addr;
            r_pend_data  <= i_data;
            r_pend_valid <= 1'b1;
          end
        end

        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule : result_writer
`default_nettype wire

// File: tb/tb_result_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_result_writer
//  Purpose  : Self-checking bench for result_writer (NDWORDS=3): directed
//             vector table, multi-cycle corner sequences and randomized
//             traffic checked against a queue-based beat model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_result_writer;

  localparam int ND = 3;
  localparam int NB = 2 * ND;

  logic          clk = 1'b0;
  logic          i_rstn;
  logic [31:0]   i_baseaddr;
  logic [31:0]   i_index;
  logic [95:0]   i_data;
  logic          i_write;
  logic          o_ready;
  logic          o_busy;
  logic          o_done;
  logic          avm_m0_write;
  logic [31:0]   avm_m0_address;
  logic [15:0]   avm_m0_writedata;
  logic [1:0]    avm_m0_byteenable;
  logic          avm_m0_waitrequest;

  always #5 clk = ~clk;

  result_writer #(.NDWORDS(ND)) dut (
    .i_clk              (clk),
    .i_rstn             (i_rstn),
    .i_baseaddr         (i_baseaddr),
    .i_index            (i_index),
    .i_data             (i_data),
    .i_write            (i_write),
    .o_ready            (o_ready),
    .o_busy             (o_busy),
    .o_done             (o_done),
    .avm_m0_write       (avm_m0_write),
    .avm_m0_address     (avm_m0_address),
    .avm_m0_writedata   (avm_m0_writedata),
    .avm_m0_byteenable  (avm_m0_byteenable),
    .avm_m0_waitrequest (avm_m0_waitrequest)
  );

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Reference: record address and halfword selection from the plain rules.
  function automatic logic [31:0] ref_rec(input logic [31:0] base, input logic [31:0] idx);
    return base + idx * 32'(ND * 4);
  endfunction

  function automatic logic [15:0] ref_half(input logic [95:0] d, input int b);
    logic [31:0] w;
    w = d[32*(b/2) +: 32];
    return (b % 2 == 1) ? w[31:16] : w[15:0];
  endfunction

  // --------------------------------------------------------------------------
  // Beat-level model: every accepted request expands into NB expected beats.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] addr;
    logic [15:0] data;
    bit          last;
  } beat_t;

  beat_t       q[$];
  bit          mon_en     = 1'b0;
  bit          exp_done   = 1'b0;
  bit          prev_stall = 1'b0;
  logic [31:0] prev_addr;
  logic [15:0] prev_data;

  always @(negedge clk) begin : monitor
    beat_t e;
    if (mon_en) begin
      chk("o_done_pulse", o_done, exp_done);
      exp_done = 1'b0;
      if (prev_stall) begin
        chk("stall_write_held", avm_m0_write, 1);
        chk("stall_addr_held", avm_m0_address, prev_addr);
        chk("stall_data_held", avm_m0_writedata, prev_data);
      end
      prev_stall = 1'b0;
      if (!i_rstn) begin
        q.delete();
      end else begin
        if (avm_m0_write) begin
          chk("byteenable_writing", avm_m0_byteenable, 2'b11);
        end else begin
          chk("idle_addr", avm_m0_address, 0);
          chk("idle_data", avm_m0_writedata, 0);
          chk("idle_byteenable", avm_m0_byteenable, 0);
        end
        if (avm_m0_write && !avm_m0_waitrequest) begin
          if (q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%h required=none", avm_m0_address);
          end else begin
            e = q.pop_front();
            chk("beat_addr", avm_m0_address, e.addr);
            chk("beat_data", avm_m0_writedata, e.data);
            exp_done = e.last;
          end
        end
        if (avm_m0_write && avm_m0_waitrequest) begin
          prev_stall = 1'b1;
          prev_addr  = avm_m0_address;
          prev_data  = avm_m0_writedata;
        end
        if (i_write && o_ready) begin
          for (int b = 0; b < NB; b++)
            q.push_back('{ref_rec(i_baseaddr, i_index) + 32'(2*b),
                          ref_half(i_data, b), (b == NB-1)});
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Directed vector table
  // --------------------------------------------------------------------------
  typedef struct {
    logic [31:0] base;
    logic [31:0] idx;
    logic [95:0] data;
    logic [31:0] exp_rec;
  } vec_t;

  vec_t        vt [4];
  logic [15:0] t1_half [6];

  task automatic run_record(input vec_t v, input bit explicit_data);
    i_baseaddr = v.base;
    i_index    = v.idx;
    i_data     = v.data;
    i_write    = 1'b1;
    chk("ready_before_accept", o_ready, 1);
    cyc();
    i_write = 1'b0;
    for (int b = 0; b < NB; b++) begin
      chk("rec_write", avm_m0_write, 1);
      chk("rec_addr", avm_m0_address, v.exp_rec + 32'(2*b));
      chk("rec_data", avm_m0_writedata,
          explicit_data ? {16'h0, t1_half[b]} : {16'h0, ref_half(v.data, b)});
      cyc();
    end
    chk("rec_done_after_last", o_done, 1);
    chk("rec_write_off", avm_m0_write, 0);
    cyc();
    chk("rec_done_one_cycle", o_done, 0);
    chk("rec_not_busy", o_busy, 0);
  endtask

  initial begin : main
    int n;
    int extra_acc;
    int done_at[$];
    bit acc_now;

    vt[0] = '{32'h0000_1000, 32'd2, 96'h00000000_00010002_DEADBEEF, 32'h0000_1018};
    vt[1] = '{32'hFFFF_FFF8, 32'd1, 96'h11112222_33334444_55556666, 32'h0000_0004};
    vt[2] = '{32'h0000_0000, 32'd0, 96'hCAFEF00D_01234567_89ABCDEF, 32'h0000_0000};
    vt[3] = '{32'h2000_0000, 32'h1555_5556, 96'hA5A5A5A5_5A5A5A5A_FFFF0000, 32'h2000_0008};
    t1_half = '{16'hBEEF, 16'hDEAD, 16'h0002, 16'h0001, 16'h0000, 16'h0000};

    i_rstn = 1'b0;
    i_baseaddr = '0;
    i_index = '0;
    i_data = '0;
    i_write = 1'b0;
    avm_m0_waitrequest = 1'b0;
    repeat (3) cyc();

    chk("rst_write", avm_m0_write, 0);
    chk("rst_addr", avm_m0_address, 0);
    chk("rst_data", avm_m0_writedata, 0);
    chk("rst_be", avm_m0_byteenable, 0);
    chk("rst_done", o_done, 0);
    chk("rst_busy", o_busy, 0);
    i_rstn = 1'b1;
    mon_en = 1'b1;
    cyc();
    chk("post_rst_ready", o_ready, 1);
    chk("post_rst_busy", o_busy, 0);

    // Table: basic record, wrap, zero address, truncated index product
    for (int i = 0; i < 4; i++) run_record(vt[i], (i == 0));

    // Stall on beat 1 for three cycles
    i_baseaddr = vt[0].base;
    i_index    = vt[0].idx;
    i_data     = vt[0].data;
    i_write    = 1'b1;
    cyc();
    i_write = 1'b0;
    chk("stall_beat0_addr", avm_m0_address, 32'h1018);
    cyc();
    avm_m0_waitrequest = 1'b1;
    for (int s = 0; s < 3; s++) begin
      chk("stall_hold_addr", avm_m0_address, 32'h101A);
      chk("stall_hold_data", avm_m0_writedata, 32'hDEAD);
      cyc();
    end
    avm_m0_waitrequest = 1'b0;
    chk("stall_4th_addr", avm_m0_address, 32'h101A);
    chk("stall_4th_data", avm_m0_writedata, 32'hDEAD);
    n = 0;
    while (!o_done && n < 20) begin
      cyc();
      n++;
    end
    chk("stall_done_latency", n, 5);
    cyc();

    // Back-to-back records with a third request held while o_ready is low
    i_baseaddr = 32'h0000_3000;
    i_index    = 32'd0;
    i_data     = {$urandom, $urandom, $urandom};
    i_write    = 1'b1;
    cyc();
    i_index = 32'd1;
    i_data  = {$urandom, $urandom, $urandom};
    cyc();
    chk("b2b_ready_low", o_ready, 0);
    chk("b2b_busy", o_busy, 1);
    i_index = 32'd2;
    i_data  = {$urandom, $urandom, $urandom};
    extra_acc = 0;
    for (int c = 1; c <= 19; c++) begin
      acc_now = i_write && o_ready;
      if (c < 18) chk("b2b_no_gap", avm_m0_write, 1);
      if (o_done) done_at.push_back(c);
      cyc();
      if (acc_now) begin
        extra_acc++;
        i_write = 1'b0;
      end
    end
    chk("held_req_captured_once", extra_acc, 1);
    chk("b2b_done_count", done_at.size(), 3);
    for (int i = 0; i < done_at.size() && i < 3; i++)
      chk("b2b_done_cycle", done_at[i], 6 * (i + 1));
    cyc();

    // Reset in the middle of a record
    i_baseaddr = vt[0].base;
    i_index    = vt[0].idx;
    i_data     = vt[0].data;
    i_write    = 1'b1;
    cyc();
    i_write = 1'b0;
    repeat (3) cyc();
    chk("pre_abort_beat3_addr", avm_m0_address, 32'h101E);
    i_rstn = 1'b0;
    cyc();
    chk("abort_write", avm_m0_write, 0);
    chk("abort_be", avm_m0_byteenable, 0);
    i_rstn = 1'b1;
    for (int c = 0; c < 8; c++) begin
      chk("abort_no_done", o_done, 0);
      chk("abort_no_write", avm_m0_write, 0);
      cyc();
    end
    chk("abort_ready", o_ready, 1);
    run_record(vt[0], 1'b1);

    // Randomized traffic against the beat model
    for (int c = 0; c < 600; c++) begin
      i_write            = ($urandom_range(0, 2) == 0);
      i_baseaddr         = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0000_8000;
      i_index            = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 500));
      i_data             = {$urandom, $urandom, $urandom};
      avm_m0_waitrequest = ($urandom_range(0, 3) == 0);
      cyc();
    end
    i_write = 1'b0;
    avm_m0_waitrequest = 1'b0;
    n = 0;
    while (o_busy && n < 200) begin
      cyc();
      n++;
    end
    chk("drain_idle", o_busy, 0);
    repeat (2) cyc();
    chk("model_queue_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_result_writer
`default_nettype wire
